// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map, STATUS layout, frame states; UART_TX_PARITY_EN adds PARITY
`ifndef UART_PKG_SV
`define UART_PKG_SV

`define UART_DIV(clk_freq, baud) ((clk_freq) / (baud))

package uart_pkg;

  localparam logic [1:0] UART_REG_TXDATA = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;

  localparam int UART_ST_EMPTY    = 1;
  localparam int UART_ST_FULL     = 2;
  localparam int UART_ST_BUSY     = 3;
  localparam int UART_ST_OVERFLOW = 4;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    TX_PARITY = 3'd4
`endif
  } tx_state_e;

endpackage

`endif

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO; a push on a full FIFO succeeds only alongside a pop
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - bus-mapped UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN)
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ren,
  input  logic        wen,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_tx
);

  localparam int DIV = `UART_DIV(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);

  tx_state_e       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     data_out_q, status;
  logic            pop, tx_line, bit_end;
  logic            wr_tx, rd_status, drop;
  logic [7:0]      fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;
  logic            unused_data;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign unused_data = ^data_in[31:8];

  assign wr_tx     = wen && (address == UART_REG_TXDATA);
  assign rd_status = ren && (address == UART_REG_STATUS);
  assign drop      = wr_tx && fifo_full && !pop;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (wr_tx),
    .pop_i   (pop),
    .wdata_i (data_in[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_end = (baud_q == BW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_line = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = TX_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_rdata;
`endif
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (bit_end) begin
          state_d = TX_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      TX_DATA: begin
        tx_line = shift_q[0];
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        tx_line = par_q;
        if (bit_end) begin
          state_d = TX_STOP;
          baud_d  = '0;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          state_d = TX_IDLE;
          baud_d  = '0;
        end
      end
      default: begin
        state_d = TX_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // A drop in the same cycle as a STATUS read leaves overflow set.
  always_comb begin
    ovf_d = ovf_q;
    if (rd_status) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_comb begin
    status                   = '0;
    status[UART_ST_EMPTY]    = (fifo_count == '0);
    status[UART_ST_FULL]     = (fifo_count == (AW+1)'(FIFO_DEPTH));
    status[UART_ST_BUSY]     = (state_q != TX_IDLE);
    status[UART_ST_OVERFLOW] = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      ovf_q      <= 1'b0;
      data_out_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      if (ren) data_out_q <= rd_status ? status : 32'd0;
    end
  end

  assign data_out = data_out_q;
  assign uart_tx  = tx_line;

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - directed self-checking bench for uart_tx_controller
module tb_uart_tx_controller;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  uart_tx_controller #(
    .CLK_FREQ   (1000),
    .BAUD       (100),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ren      (ren),
    .wen      (wen),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    wen = 1'b1; address = a; data_in = d;
    @(negedge clk);
    wen = 1'b0; address = 2'd0; data_in = 32'd0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    ren = 1'b1; address = a;
    @(negedge clk);
    ren = 1'b0; address = 2'd0;
    v = data_out;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int k;
    k = i / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && FB == 11) return ^b;
    return 1'b1;
  endfunction

  // Sample index `start` is the current negedge; index 0 is the first START cycle.
  task automatic check_frame(input logic [7:0] b, input int start, input string tag);
    int bad;
    bad = 0;
    for (int i = start; i < FB*DIV; i++) begin
      if (i != start) @(negedge clk);
      if (uart_tx !== exp_bit(b, i)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic idle_for(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad++;
    end
    chk(tag, bad, 0);
  endtask

  logic [31:0] rd;
  logic [7:0]  fb [6];

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    reset = 1'b0;

    idle_for(50, "idle_after_reset");
    @(negedge clk);
    read_reg(2'd1, rd);
    chk("status_reset", rd, 32'h2);
    read_reg(2'd0, rd);
    chk("txdata_read_zero", rd, 32'd0);
    read_reg(2'd1, rd);
    read_reg(2'd2, rd);
    chk("reserved_read_zero", rd, 32'd0);
    write_reg(2'd3, 32'h77);
    idle_for(20, "reserved_write_ignored");
    read_reg(2'd1, rd);
    chk("status_after_reserved", rd, 32'h2);
    repeat (3) @(negedge clk);
    chk("data_out_hold", data_out, 32'h2);

    // Single frame 0x55
    write_reg(2'd0, 32'h55);
    chk("pre_start_high", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    check_frame(8'h55, 0, "frame_55");
    @(negedge clk);
    chk("post_55_idle", {31'd0, uart_tx}, 32'd1);

    // Back-to-back frames with a single idle cycle between
    @(negedge clk);
    write_reg(2'd0, 32'hA5);
    write_reg(2'd0, 32'h3C);
    check_frame(8'hA5, 0, "frame_A5");
    @(negedge clk);
    chk("gap_one_idle", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    check_frame(8'h3C, 0, "frame_3C");
    @(negedge clk);
    read_reg(2'd1, rd);
    chk("status_after_b2b", rd, 32'h2);

    // Six writes into a 4-deep FIFO: sixth is dropped
    for (int i = 0; i < 6; i++) write_reg(2'd0, 32'h11 * (i + 1));
    read_reg(2'd1, rd);
    chk("status_overflow", rd, 32'h1C);
    read_reg(2'd1, rd);
    chk("status_overflow_cleared", rd, 32'h0C);
    repeat (550) @(negedge clk);
    read_reg(2'd1, rd);
    chk("status_drained", rd, 32'h2);

    // Reset in the middle of bit 3 with bytes queued
    write_reg(2'd0, 32'hF0);
    write_reg(2'd0, 32'h12);
    write_reg(2'd0, 32'h34);
    repeat (40) @(negedge clk);
    chk("mid_frame_bit3", {31'd0, uart_tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_midframe_high", {31'd0, uart_tx}, 32'd1);
    reset = 1'b0;
    idle_for(300, "no_frames_after_reset");
    read_reg(2'd1, rd);
    chk("status_after_reset", rd, 32'h2);

    // Full FIFO, write lands on the engine's pop cycle
    fb[0] = 8'hC1; fb[1] = 8'h82; fb[2] = 8'h4B; fb[3] = 8'h0F; fb[4] = 8'hE7; fb[5] = 8'h69;
    for (int i = 0; i < 5; i++) write_reg(2'd0, {24'd0, fb[i]});
    check_frame(fb[0], 3, "full_frame0");
    @(negedge clk);
    chk("full_gap0", {31'd0, uart_tx}, 32'd1);
    write_reg(2'd0, {24'd0, fb[5]});
    check_frame(fb[1], 0, "full_frame1");
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      chk("full_gap", {31'd0, uart_tx}, 32'd1);
      @(negedge clk);
      check_frame(fb[i], 0, $sformatf("full_frame%0d", i));
    end
    @(negedge clk);
    read_reg(2'd1, rd);
    chk("status_no_overflow", rd, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
